os_matmul_sequencer: RTL and testbench

//  Sequences one output-stationary (OS) matmul on a ROWS x COLS array of traditional MAC PEs.

---
 rtl/os_matmul_sequencer_pkg.sv | 23 ++
 rtl/os_feed_window.sv | 21 ++
 rtl/os_matmul_sequencer.sv | 179 +++++++++++++++++
 tb/tb_os_matmul_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_matmul_sequencer_pkg.sv
// Shared definitions for the output-stationary matmul sequencer.
package os_matmul_sequencer_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_FEED  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StClear = ST_CLEAR,
      StFeed  = ST_FEED,
      StFlush = ST_FLUSH,
      StDrain = ST_DRAIN,
      StDone  = ST_DONE
   } state_e;

   // PE input register stage plus the accumulator update stage.
   localparam int unsigned FLUSH_CYCLES = 2;

endpackage

// File: rtl/os_feed_window.sv
// Skewed operand window: lane i is live while i <= t < i + k_len.
module os_feed_window #(
   parameter int unsigned N   = 4,
   parameter int unsigned T_W = 10,
   parameter int unsigned K_W = 8
) (
   input  logic [T_W-1:0] t,
   input  logic [K_W-1:0] k_len,
   output logic [N-1:0]   en
);

   // One extra bit keeps i + k_len from wrapping.
   always_comb begin
      en = '0;
      for (int unsigned i = 0; i < N; i++) begin
         en[i] = ({1'b0, t} >= (T_W+1)'(i)) &&
                 ({1'b0, t} < ((T_W+1)'(i) + (T_W+1)'(k_len)));
      end
   end

endmodule

// File: rtl/os_matmul_sequencer.sv
// Sequences one output-stationary tile: clear, skewed feed, flush, drain, optional second pass.
module os_matmul_sequencer
   import os_matmul_sequencer_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4,
   parameter int unsigned K_W  = 8,
   parameter int unsigned T_W  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [K_W-1:0]           k_len,
   input  logic                     recompute_en,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic                     pass_id,
   output logic                     array_rst,
   output logic                     fsm_op2_select,
   output logic                     stat_bit,
   output logic                     fsm_out_select,
   output logic [T_W-1:0]           feed_t,
   output logic [ROWS-1:0]          row_feed_en,
   output logic [COLS-1:0]          col_feed_en,
   output logic [$clog2(ROWS)-1:0]  drain_row
);

   localparam int unsigned RW      = $clog2(ROWS);
   localparam int unsigned CNT_MAX = (ROWS > FLUSH_CYCLES) ? ROWS : FLUSH_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

   state_e          state_q;
   logic [K_W-1:0]  k_len_q;
   logic            recomp_q;
   logic            pass_q;
   logic [T_W-1:0]  feed_t_q;
   logic [CW-1:0]   cnt_q;
   logic [RW-1:0]   drain_row_q;
   logic            busy_q;
   logic            done_q;
   logic            array_rst_q;
   logic            out_sel_q;

   logic [T_W-1:0]  feed_last;
   logic [ROWS-1:0] row_win;
   logic [COLS-1:0] col_win;

   // Last feed index: k_len + ROWS + COLS - 3 (the far corner PE sees its last operand pair).
   assign feed_last = T_W'(k_len_q) + T_W'(ROWS + COLS - 3);

   // FSM with registered Moore outputs; counters default to 0 so every state entry restarts them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         k_len_q     <= '0;
         recomp_q    <= 1'b0;
         pass_q      <= 1'b0;
         feed_t_q    <= '0;
         cnt_q       <= '0;
         drain_row_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         array_rst_q <= 1'b1;
         out_sel_q   <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         array_rst_q <= 1'b0;
         out_sel_q   <= 1'b0;
         feed_t_q    <= '0;
         cnt_q       <= '0;
         drain_row_q <= '0;
         if (abort) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            array_rst_q <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     k_len_q     <= k_len;
                     recomp_q    <= recompute_en;
                     pass_q      <= 1'b0;
                     busy_q      <= 1'b1;
                     array_rst_q <= 1'b1;
                     state_q     <= StClear;
                  end
               end
               StClear: begin
                  if (k_len_q == '0) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StFeed;
                  end
               end
               StFeed: begin
                  if (feed_t_q == feed_last) begin
                     state_q <= StFlush;
                  end else begin
                     feed_t_q <= feed_t_q + 1'b1;
                  end
               end
               StFlush: begin
                  if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                     out_sel_q   <= 1'b1;
                     drain_row_q <= RW'(ROWS - 1);
                     state_q     <= StDrain;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StDrain: begin
                  if (cnt_q == CW'(ROWS - 1)) begin
                     if (!pass_q && recomp_q) begin
                        pass_q      <= 1'b1;
                        array_rst_q <= 1'b1;
                        state_q     <= StClear;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                     end
                  end else begin
                     cnt_q       <= cnt_q + 1'b1;
                     out_sel_q   <= 1'b1;
                     drain_row_q <= drain_row_q - 1'b1;
                  end
               end
               StDone: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   os_feed_window #(
      .N   (ROWS),
      .T_W (T_W),
      .K_W (K_W)
   ) u_row_window (
      .t     (feed_t_q),
      .k_len (k_len_q),
      .en    (row_win)
   );

   os_feed_window #(
      .N   (COLS),
      .T_W (T_W),
      .K_W (K_W)
   ) u_col_window (
      .t     (feed_t_q),
      .k_len (k_len_q),
      .en    (col_win)
   );

   // Enables track registered feed_t, so they move on the same edge as the index.
   always_comb begin
      row_feed_en = (state_q == StFeed) ? row_win : '0;
      col_feed_en = (state_q == StFeed) ? col_win : '0;
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass_id        = pass_q;
   assign array_rst      = array_rst_q;
   assign fsm_op2_select = 1'b0;
   assign stat_bit       = 1'b0;
   assign fsm_out_select = out_sel_q;
   assign feed_t         = feed_t_q;
   assign drain_row      = drain_row_q;

endmodule

// File: tb/tb_os_matmul_sequencer.sv
// Bench: sequencer driving a behavioural 4x4 OS MAC array; scoreboard checks drains and done.
module tb_os_matmul_sequencer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int K_W  = 8;
   localparam int T_W  = 10;
   localparam int KMAX = 3;
   localparam int KIND_DONE  = 0;
   localparam int KIND_DRAIN = 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic [K_W-1:0]  k_len = '0;
   logic            recompute_en = 1'b0;
   logic            abort = 1'b0;
   logic            busy, done, pass_id, array_rst, fsm_op2_select, stat_bit, fsm_out_select;
   logic [T_W-1:0]  feed_t;
   logic [ROWS-1:0] row_feed_en;
   logic [COLS-1:0] col_feed_en;
   logic [1:0]      drain_row;

   always #5 clk = ~clk;

   os_matmul_sequencer #(
      .ROWS (ROWS),
      .COLS (COLS),
      .K_W  (K_W),
      .T_W  (T_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .k_len          (k_len),
      .recompute_en   (recompute_en),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .pass_id        (pass_id),
      .array_rst      (array_rst),
      .fsm_op2_select (fsm_op2_select),
      .stat_bit       (stat_bit),
      .fsm_out_select (fsm_out_select),
      .feed_t         (feed_t),
      .row_feed_en    (row_feed_en),
      .col_feed_en    (col_feed_en),
      .drain_row      (drain_row)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;
   logic chk_drain = 1'b1;

   typedef struct {
      int          kind;
      int          row;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [15:0] a_m [ROWS][KMAX];
   logic [15:0] b_m [KMAX][COLS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] win(input int t, input int k, input int n);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < n; i++) if (t >= i && t < i + k) w[i] = 1'b1;
      return w;
   endfunction

   function automatic logic [63:0] exp_row(input int r, input int k);
      logic [63:0] d;
      logic [15:0] s;
      d = '0;
      for (int c = 0; c < COLS; c++) begin
         s = '0;
         for (int j = 0; j < k; j++) s = s + a_m[r][j] * b_m[j][c];
         d[c*16 +: 16] = s;
      end
      return d;
   endfunction

   function automatic int latency(input int k, input int passes);
      if (k == 0) return 2;
      return passes * (1 + (k + ROWS + COLS - 2) + 2 + ROWS) + 1;
   endfunction

   task automatic push_run(input int k, input int passes);
      exp_t e;
      if (k != 0) begin
         for (int p = 0; p < passes; p++) begin
            for (int r = ROWS - 1; r >= 0; r--) begin
               e.kind = KIND_DRAIN;
               e.row  = r;
               e.data = exp_row(r, k);
               exp_q.push_back(e);
            end
         end
      end
      e.kind = KIND_DONE;
      e.row  = 0;
      e.data = 64'(latency(k, passes));
      exp_q.push_back(e);
   endtask

   // Leaves the caller at the negedge of cycle 1 (CLEAR).
   task automatic issue(input int k, input logic re);
      @(negedge clk);
      k_len        = K_W'(k);
      recompute_en = re;
      start        = 1'b1;
      start_cyc    = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Feeders and behavioural OS array.
   logic [15:0] row_val [ROWS];
   logic [15:0] col_val [COLS];
   logic [15:0] lq  [ROWS][COLS];
   logic [15:0] tq  [ROWS][COLS];
   logic [15:0] acc [ROWS][COLS];

   always_comb begin
      int k;
      k = 0;
      for (int r = 0; r < ROWS; r++) begin
         row_val[r] = '0;
         k = int'(feed_t) - r;
         if (row_feed_en[r] && k >= 0 && k < KMAX) row_val[r] = a_m[r][k[1:0]];
      end
      for (int c = 0; c < COLS; c++) begin
         col_val[c] = '0;
         k = int'(feed_t) - c;
         if (col_feed_en[c] && k >= 0 && k < KMAX) col_val[c] = b_m[k[1:0]][c];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (array_rst) begin
               lq[r][c]  <= '0;
               tq[r][c]  <= '0;
               acc[r][c] <= '0;
            end else begin
               acc[r][c] <= acc[r][c] + lq[r][c] * tq[r][c];
            end
         end
      end
      if (!array_rst) begin
         for (int r = 0; r < ROWS; r++) begin
            lq[r][0] <= row_val[r];
            for (int c = 1; c < COLS; c++) lq[r][c] <= lq[r][c-1];
         end
         for (int c = 0; c < COLS; c++) begin
            tq[0][c] <= col_val[c];
            for (int r = 1; r < ROWS; r++) tq[r][c] <= tq[r-1][c];
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT presents a drain beat or a done pulse.
   exp_t        mon_e;
   logic [63:0] mon_row;
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_kind", 64'(KIND_DONE), 64'(mon_e.kind));
               chk("done_latency", 64'(cyc - start_cyc), mon_e.data);
            end
         end
         if (fsm_out_select && chk_drain) begin
            mon_row = '0;
            for (int c = 0; c < COLS; c++) mon_row[c*16 +: 16] = acc[drain_row][c];
            if (exp_q.size() == 0) begin
               chk("drain_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("drain_kind", 64'(KIND_DRAIN), 64'(mon_e.kind));
               chk("drain_row", 64'(drain_row), 64'(mon_e.row));
               chk("drain_data", mon_row, mon_e.data);
            end
         end
      end
   end

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_pass"}, 64'(pass_id), 64'd0);
      chk({tag, "_feed_t"}, 64'(feed_t), 64'd0);
      chk({tag, "_outsel"}, 64'(fsm_out_select), 64'd0);
      chk({tag, "_drow"}, 64'(drain_row), 64'd0);
      chk({tag, "_rowen"}, 64'(row_feed_en), 64'd0);
      chk({tag, "_colen"}, 64'(col_feed_en), 64'd0);
      chk({tag, "_op2"}, 64'(fsm_op2_select), 64'd0);
      chk({tag, "_stat"}, 64'(stat_bit), 64'd0);
   endtask

   initial begin
      logic [63:0] en_or;
      int          rst_cnt;
      logic        in_feed;

      a_m[0][0] = 16'h1234; a_m[0][1] = 16'hBEEF; a_m[0][2] = 16'h0007;
      a_m[1][0] = 16'hFFFF; a_m[1][1] = 16'h0002; a_m[1][2] = 16'h8001;
      a_m[2][0] = 16'h00A5; a_m[2][1] = 16'h5A5A; a_m[2][2] = 16'hC3C3;
      a_m[3][0] = 16'h7FFF; a_m[3][1] = 16'h0100; a_m[3][2] = 16'h0F0F;
      b_m[0][0] = 16'h0003; b_m[0][1] = 16'hABCD; b_m[0][2] = 16'h1111; b_m[0][3] = 16'hFFFE;
      b_m[1][0] = 16'h2468; b_m[1][1] = 16'h0010; b_m[1][2] = 16'h9999; b_m[1][3] = 16'h0001;
      b_m[2][0] = 16'hDEAD; b_m[2][1] = 16'h4321; b_m[2][2] = 16'h0005; b_m[2][3] = 16'h8000;

      // Reset state.
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      chk("reset_array_rst", 64'(array_rst), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_array_rst", 64'(array_rst), 64'd0);

      // k_len=3 single pass: timeline and drained products.
      push_run(3, 1);
      issue(3, 1'b0);
      for (int i = 1; i <= 18; i++) begin
         in_feed = (i >= 2 && i <= 10);
         chk("t1_busy", 64'(busy), 64'(i <= 17));
         chk("t1_array_rst", 64'(array_rst), 64'(i == 1));
         chk("t1_outsel", 64'(fsm_out_select), 64'(i >= 13 && i <= 16));
         if (i >= 13 && i <= 16) chk("t1_drain_row", 64'(drain_row), 64'(16 - i));
         chk("t1_feed_t", 64'(feed_t), in_feed ? 64'(i - 2) : 64'd0);
         chk("t1_row_en", 64'(row_feed_en), in_feed ? win(i - 2, 3, ROWS) : 64'd0);
         chk("t1_col_en", 64'(col_feed_en), in_feed ? win(i - 2, 3, COLS) : 64'd0);
         @(negedge clk);
      end

      // k_len=0: CLEAR straight to DONE, no feed.
      push_run(0, 1);
      issue(0, 1'b0);
      en_or = '0;
      for (int i = 1; i <= 3; i++) begin
         if (i == 1) chk("t3_array_rst", 64'(array_rst), 64'd1);
         en_or = en_or | 64'(row_feed_en) | 64'(col_feed_en);
         if (i == 3) chk("t3_busy_after", 64'(busy), 64'd0);
         @(negedge clk);
      end
      chk("t3_no_feed", en_or, 64'd0);

      // Recompute: two passes, one done.
      push_run(2, 2);
      issue(2, 1'b1);
      rst_cnt = 0;
      for (int i = 1; i <= 32; i++) begin
         if (array_rst) rst_cnt++;
         if (i == 15) chk("t4_pass0", 64'(pass_id), 64'd0);
         if (i == 16) chk("t4_pass1", 64'(pass_id), 64'd1);
         if (i == 16) chk("t4_busy_mid", 64'(busy), 64'd1);
         if (i == 32) chk("t4_busy_end", 64'(busy), 64'd0);
         @(negedge clk);
      end
      chk("t4_array_rst_pulses", 64'(rst_cnt), 64'd2);

      // Abort on feed cycle 3; a start issued while busy must be ignored.
      issue(3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; k_len = '0; recompute_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_feed_t", 64'(feed_t), 64'd3);
      chk("t5_row_en", 64'(row_feed_en), 64'b1110);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_array_rst", 64'(array_rst), 64'd1);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_pass", 64'(pass_id), 64'd0);
      chk("t5_row_en_off", 64'(row_feed_en), 64'd0);
      @(negedge clk);
      chk("t5_array_rst_once", 64'(array_rst), 64'd0);
      chk("t5_idle", 64'(busy), 64'd0);
      repeat (20) @(negedge clk);

      // Async reset mid-DRAIN, then a clean k_len=1 run.
      chk_drain = 1'b0;
      issue(3, 1'b0);
      repeat (13) @(negedge clk);
      chk("t6_in_drain", 64'(fsm_out_select), 64'd1);
      rst = 1'b0;
      #1;
      chk_quiet("t6_reset");
      chk("t6_array_rst", 64'(array_rst), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_drain = 1'b1;
      push_run(1, 1);
      issue(1, 1'b0);
      repeat (20) @(negedge clk);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
